// File: rtl/alu_seq_if.sv
// Bus between the execution sequencer (initiator) and the shared combinational ALU.
// The sequencer drives op/a/b; the ALU answers p/bcond combinationally in the same cycle.
interface alu_seq_if;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_p_i;
    logic        bcond_i;

    modport master (
        output alu_op_o,
        output alu_a_o,
        output alu_b_o,
        input  alu_p_i,
        input  bcond_i
    );

    modport slave (
        input  alu_op_o,
        input  alu_a_o,
        input  alu_b_o,
        output alu_p_i,
        output bcond_i
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle execution sequencer: time-multiplexes one combinational ALU over
// PC-increment, execute and branch-target steps for one decoded instruction.
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    // Handshake: start_i is "valid"; ready is busy_o == 0. A transfer happens on the
    // rising edge where start_i=1 and the sequencer is IDLE; start_i at any other time is dropped.
    input  logic        start_i,
    input  logic [2:0]  inst_class_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] imm_i,
    alu_seq_if.master   alu,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rd_data_o,
    output logic        rd_we_o,
    output logic [31:0] next_pc_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PCINC = 3'd1,
        S_EXEC  = 3'd2,
        S_TGT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_BNE = 4'd8;
    localparam logic [3:0] OP_BLT = 4'd9;
    localparam logic [3:0] OP_BGE = 4'd10;
    localparam logic [3:0] OP_NOP = 4'd15;

    localparam logic [2:0] CLS_R    = 3'd0;
    localparam logic [2:0] CLS_I    = 3'd1;
    localparam logic [2:0] CLS_MEM  = 3'd2;
    localparam logic [2:0] CLS_BR   = 3'd3;
    localparam logic [2:0] CLS_JAL  = 3'd4;
    localparam logic [2:0] CLS_JALR = 3'd5;

    state_t      state, state_nxt;
    logic [2:0]  cls_q, f3_q;
    logic        f7_q;
    logic [31:0] pc_q, rs1_q, rs2_q, imm_q, pc4_q;
    logic        busy_q, done_q, rd_we_q;
    logic [31:0] rd_data_q, next_pc_q;

    logic [3:0]  exec_op;
    logic [31:0] exec_a, exec_b;
    logic        exec_wr;
    logic        branch_taken;
    logic [3:0]  op_mux;
    logic [31:0] a_mux, b_mux;

    // Execute-step decode, purely from the latched instruction.
    always_comb begin
        exec_op = OP_NOP;
        exec_a  = rs1_q;
        exec_b  = rs2_q;
        exec_wr = 1'b0;
        case (cls_q)
            CLS_R, CLS_I: begin
                if (cls_q == CLS_I) exec_b = imm_q;
                exec_wr = 1'b1;
                case (f3_q)
                    3'b000:  exec_op = (cls_q == CLS_R && f7_q) ? OP_SUB : OP_ADD;
                    3'b001:  exec_op = OP_SLL;
                    3'b100:  exec_op = OP_XOR;
                    3'b101:  exec_op = OP_SRL;
                    3'b110:  exec_op = OP_OR;
                    3'b111:  exec_op = OP_AND;
                    default: begin
                        exec_op = OP_NOP;
                        exec_wr = 1'b0;
                    end
                endcase
            end
            CLS_MEM: begin
                exec_op = OP_ADD;
                exec_b  = imm_q;
            end
            CLS_BR: begin
                case (f3_q)
                    3'b000:  exec_op = OP_BEQ;
                    3'b001:  exec_op = OP_BNE;
                    3'b100:  exec_op = OP_BLT;
                    3'b101:  exec_op = OP_BGE;
                    default: exec_op = OP_NOP;
                endcase
            end
            CLS_JAL: begin
                exec_op = OP_ADD;
                exec_a  = pc_q;
                exec_b  = imm_q;
            end
            CLS_JALR: begin
                exec_op = OP_ADD;
                exec_b  = imm_q;
            end
            default: begin
                exec_op = OP_NOP;
                exec_a  = 32'd0;
                exec_b  = 32'd0;
            end
        endcase
    end

    // An unsupported branch funct3 drives NOP, so whatever bcond says is ignored.
    assign branch_taken = (cls_q == CLS_BR) && (exec_op != OP_NOP) && alu.bcond_i;

    always_comb begin
        op_mux = OP_NOP;
        a_mux  = 32'd0;
        b_mux  = 32'd0;
        case (state)
            S_PCINC: begin
                op_mux = OP_ADD;
                a_mux  = pc_q;
                b_mux  = 32'd4;
            end
            S_EXEC: begin
                op_mux = exec_op;
                a_mux  = exec_a;
                b_mux  = exec_b;
            end
            S_TGT: begin
                op_mux = OP_ADD;
                a_mux  = pc_q;
                b_mux  = imm_q;
            end
            default: ;
        endcase
    end

    assign alu.alu_op_o = op_mux;
    assign alu.alu_a_o  = a_mux;
    assign alu.alu_b_o  = b_mux;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_PCINC;
            S_PCINC: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = branch_taken ? S_TGT : S_DONE;
            S_TGT:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cls_q     <= 3'd0;
            f3_q      <= 3'd0;
            f7_q      <= 1'b0;
            pc_q      <= 32'd0;
            rs1_q     <= 32'd0;
            rs2_q     <= 32'd0;
            imm_q     <= 32'd0;
            pc4_q     <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_we_q   <= 1'b0;
            rd_data_q <= 32'd0;
            next_pc_q <= 32'd0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != S_IDLE);
            done_q <= (state_nxt == S_DONE);
            if (state == S_IDLE && start_i) begin
                cls_q <= inst_class_i;
                f3_q  <= funct3_i;
                f7_q  <= funct7b5_i;
                pc_q  <= pc_i;
                rs1_q <= rs1_i;
                rs2_q <= rs2_i;
                imm_q <= imm_i;
            end
            case (state)
                S_PCINC: pc4_q <= alu.alu_p_i;
                S_EXEC: begin
                    case (cls_q)
                        CLS_R, CLS_I: begin
                            rd_data_q <= exec_wr ? alu.alu_p_i : 32'd0;
                            rd_we_q   <= exec_wr;
                            next_pc_q <= pc4_q;
                        end
                        CLS_MEM: begin
                            rd_data_q <= alu.alu_p_i;
                            rd_we_q   <= 1'b0;
                            next_pc_q <= pc4_q;
                        end
                        CLS_BR: begin
                            rd_data_q <= 32'd0;
                            rd_we_q   <= 1'b0;
                            if (!branch_taken) next_pc_q <= pc4_q;
                        end
                        CLS_JAL: begin
                            rd_data_q <= pc4_q;
                            rd_we_q   <= 1'b1;
                            next_pc_q <= alu.alu_p_i;
                        end
                        CLS_JALR: begin
                            rd_data_q <= pc4_q;
                            rd_we_q   <= 1'b1;
                            next_pc_q <= {alu.alu_p_i[31:1], 1'b0};
                        end
                        default: begin
                            rd_data_q <= 32'd0;
                            rd_we_q   <= 1'b0;
                            next_pc_q <= pc4_q;
                        end
                    endcase
                end
                S_TGT: begin
                    next_pc_q <= alu.alu_p_i;
                    rd_we_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_we_o     = rd_we_q;
    assign rd_data_o   = rd_data_q;
    assign next_pc_o   = next_pc_q;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: combinational ALU model, instruction-level reference model,
// per-cycle compare process and directed plus randomized instruction streams.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  inst_class_i = '0;
    logic [2:0]  funct3_i = '0;
    logic        funct7b5_i = 1'b0;
    logic [31:0] pc_i = '0, rs1_i = '0, rs2_i = '0, imm_i = '0;
    logic        busy_o, done_o, rd_we_o;
    logic [31:0] rd_data_o, next_pc_o;
    logic [2:0]  dbg_state_o;

    alu_seq_if alu_bus ();

    alu_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .inst_class_i (inst_class_i),
        .funct3_i     (funct3_i),
        .funct7b5_i   (funct7b5_i),
        .pc_i         (pc_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .imm_i        (imm_i),
        .alu          (alu_bus.master),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rd_data_o    (rd_data_o),
        .rd_we_o      (rd_we_o),
        .next_pc_o    (next_pc_o),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // shared combinational ALU; non-branch ops report bcond=1 so a NOP branch must ignore it
    always_comb begin
        alu_bus.alu_p_i = 32'd0;
        alu_bus.bcond_i = 1'b1;
        case (alu_bus.alu_op_o)
            4'd0:  alu_bus.alu_p_i = alu_bus.alu_a_o + alu_bus.alu_b_o;
            4'd1:  alu_bus.alu_p_i = alu_bus.alu_a_o - alu_bus.alu_b_o;
            4'd2:  alu_bus.alu_p_i = alu_bus.alu_a_o & alu_bus.alu_b_o;
            4'd3:  alu_bus.alu_p_i = alu_bus.alu_a_o | alu_bus.alu_b_o;
            4'd4:  alu_bus.alu_p_i = alu_bus.alu_a_o ^ alu_bus.alu_b_o;
            4'd5:  alu_bus.alu_p_i = alu_bus.alu_a_o << alu_bus.alu_b_o[4:0];
            4'd6:  alu_bus.alu_p_i = alu_bus.alu_a_o >> alu_bus.alu_b_o[4:0];
            4'd7:  alu_bus.bcond_i = (alu_bus.alu_a_o == alu_bus.alu_b_o);
            4'd8:  alu_bus.bcond_i = (alu_bus.alu_a_o != alu_bus.alu_b_o);
            4'd9:  alu_bus.bcond_i = ($signed(alu_bus.alu_a_o) < $signed(alu_bus.alu_b_o));
            4'd10: alu_bus.bcond_i = ($signed(alu_bus.alu_a_o) >= $signed(alu_bus.alu_b_o));
            default: ;
        endcase
    end

    // reference model: what one instruction must produce
    typedef struct packed {
        logic [2:0]  lat;
        logic [3:0]  op;
        logic        ab_chk;
        logic [31:0] a;
        logic [31:0] b;
        logic        rd_chk;
        logic [31:0] rd;
        logic        we;
        logic [31:0] npc;
        logic [31:0] pc;
        logic [31:0] imm;
    } exp_t;

    function automatic exp_t model(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] pc, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm);
        exp_t e;
        logic [31:0] b, t;
        logic tk;
        e = '0;
        e.pc = pc; e.imm = imm; e.lat = 3'd3; e.npc = pc + 32'd4;
        e.ab_chk = 1'b1; e.rd_chk = 1'b1;
        tk = 1'b0;
        case (cls)
            3'd0, 3'd1: begin
                b = (cls == 3'd0) ? rs2 : imm;
                e.a = rs1; e.b = b; e.we = 1'b1;
                case (f3)
                    3'd0: if (cls == 3'd0 && f7) begin e.op = 4'd1; e.rd = rs1 - b; end
                          else begin e.op = 4'd0; e.rd = rs1 + b; end
                    3'd1: begin e.op = 4'd5; e.rd = rs1 << b[4:0]; end
                    3'd4: begin e.op = 4'd4; e.rd = rs1 ^ b; end
                    3'd5: begin e.op = 4'd6; e.rd = rs1 >> b[4:0]; end
                    3'd6: begin e.op = 4'd3; e.rd = rs1 | b; end
                    3'd7: begin e.op = 4'd2; e.rd = rs1 & b; end
                    default: begin e.op = 4'd15; e.rd = 32'd0; e.we = 1'b0; e.ab_chk = 1'b0; end
                endcase
            end
            3'd2: begin e.op = 4'd0; e.a = rs1; e.b = imm; e.rd = rs1 + imm; end
            3'd3: begin
                e.a = rs1; e.b = rs2; e.rd_chk = 1'b0;
                case (f3)
                    3'd0: begin e.op = 4'd7;  tk = (rs1 == rs2); end
                    3'd1: begin e.op = 4'd8;  tk = (rs1 != rs2); end
                    3'd4: begin e.op = 4'd9;  tk = ($signed(rs1) < $signed(rs2)); end
                    3'd5: begin e.op = 4'd10; tk = ($signed(rs1) >= $signed(rs2)); end
                    default: begin e.op = 4'd15; e.ab_chk = 1'b0; end
                endcase
                if (tk) begin e.lat = 3'd4; e.npc = pc + imm; end
            end
            3'd4: begin
                e.op = 4'd0; e.a = pc; e.b = imm; e.npc = pc + imm; e.rd = pc + 32'd4; e.we = 1'b1;
            end
            3'd5: begin
                e.op = 4'd0; e.a = rs1; e.b = imm; t = rs1 + imm;
                e.npc = {t[31:1], 1'b0}; e.rd = pc + 32'd4; e.we = 1'b1;
            end
            default: begin e.op = 4'd15; e.ab_chk = 1'b0; e.rd = 32'd0; end
        endcase
        return e;
    endfunction

    // scoreboard state
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    exp_t        cur = '0;
    int          cur_n0 = 0;
    bit          active = 1'b0;
    logic [31:0] hold_npc = '0, hold_rd = '0;
    logic        hold_we = 1'b0, hold_rd_chk = 1'b1;
    logic [31:0] last_rd = '0, last_npc = '0, tgt_a = '0, tgt_b = '0;
    logic [3:0]  tgt_op = '0;
    logic        last_we = 1'b0;
    int          last_off = 0;
    int          done_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compare process: every non-reset cycle, sampled on the falling edge
    always @(negedge clk) begin : cmp
        int  off;
        bit  in_win, exp_done;
        logic [31:0] npc_e;
        if (!reset) begin
            off      = cyc - cur_n0;
            in_win   = active && off >= 0 && off < int'(cur.lat);
            exp_done = in_win && off == int'(cur.lat) - 1;
            chk("busy", {31'd0, busy_o}, {31'd0, in_win});
            chk("done", {31'd0, done_o}, {31'd0, exp_done});
            if (in_win && off == 0) begin
                chk("pcinc_op", {28'd0, alu_bus.alu_op_o}, 32'd0);
                chk("pcinc_a", alu_bus.alu_a_o, cur.pc);
                chk("pcinc_b", alu_bus.alu_b_o, 32'd4);
            end else if (in_win && off == 1) begin
                chk("exec_op", {28'd0, alu_bus.alu_op_o}, {28'd0, cur.op});
                if (cur.ab_chk) begin
                    chk("exec_a", alu_bus.alu_a_o, cur.a);
                    chk("exec_b", alu_bus.alu_b_o, cur.b);
                end
            end else if (in_win && off == 2 && cur.lat == 3'd4) begin
                tgt_op = alu_bus.alu_op_o; tgt_a = alu_bus.alu_a_o; tgt_b = alu_bus.alu_b_o;
                chk("tgt_op", {28'd0, alu_bus.alu_op_o}, 32'd0);
                chk("tgt_a", alu_bus.alu_a_o, cur.pc);
                chk("tgt_b", alu_bus.alu_b_o, cur.imm);
            end else begin
                chk("idle_op", {28'd0, alu_bus.alu_op_o}, 32'd15);
                chk("idle_a", alu_bus.alu_a_o, 32'd0);
                chk("idle_b", alu_bus.alu_b_o, 32'd0);
            end
            if (done_o) begin
                done_count++;
                last_off = off; last_rd = rd_data_o; last_npc = next_pc_o; last_we = rd_we_o;
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    npc_e = exp_q.pop_front();
                    chk("next_pc", next_pc_o, npc_e);
                    chk("rd_we", {31'd0, rd_we_o}, {31'd0, cur.we});
                    if (cur.rd_chk) chk("rd_data", rd_data_o, cur.rd);
                end
                hold_npc = cur.npc; hold_we = cur.we; hold_rd = cur.rd; hold_rd_chk = cur.rd_chk;
            end else if (!in_win) begin
                chk("hold_next_pc", next_pc_o, hold_npc);
                chk("hold_rd_we", {31'd0, rd_we_o}, {31'd0, hold_we});
                if (hold_rd_chk) chk("hold_rd_data", rd_data_o, hold_rd);
            end
        end
    end

    // driver tasks; all of them begin and end 1 time unit after a rising edge
    task automatic garbage();
        inst_class_i = 3'($urandom_range(0, 7));
        funct3_i     = 3'($urandom_range(0, 7));
        funct7b5_i   = 1'($urandom_range(0, 1));
        pc_i  = $urandom; rs1_i = $urandom; rs2_i = $urandom; imm_i = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy_o) chk("idle_timeout", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic issue(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input bit noise);
        wait_idle();
        inst_class_i = cls; funct3_i = f3; funct7b5_i = f7;
        pc_i = pc; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        start_i = 1'b1;
        cur     = model(cls, f3, f7, pc, rs1, rs2, imm);
        cur_n0  = cyc + 1;
        active  = 1'b1;
        exp_q.push_back(cur.npc);
        @(posedge clk); #1;
        start_i = 1'b0;
        garbage();
        if (noise) begin
            for (int k = 0; k < int'(cur.lat); k++) begin
                start_i = 1'($urandom_range(0, 1));
                garbage();
                @(posedge clk); #1;
            end
            start_i = 1'b0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; start_i = 1'b0; active = 1'b0;
        exp_q.delete();
        hold_npc = '0; hold_we = 1'b0; hold_rd = '0; hold_rd_chk = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin : main
        exp_t m;
        int   d0;
        logic [31:0] r1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_rd_we", {31'd0, rd_we_o}, 32'd0);
        chk("rst_rd_data", rd_data_o, 32'd0);
        chk("rst_next_pc", next_pc_o, 32'd0);
        chk("rst_alu_op", {28'd0, alu_bus.alu_op_o}, 32'd15);

        // model pins
        m = model(3'd0, 3'd0, 1'b1, 32'h40, 32'd10, 32'd3, 32'd0);
        chk("model_sub_rd", m.rd, 32'd7);
        m = model(3'd5, 3'd0, 1'b0, 32'h80, 32'h203, 32'd0, 32'd4);
        chk("model_jalr_npc", m.npc, 32'h206);

        // R SUB
        issue(3'd0, 3'd0, 1'b1, 32'h40, 32'd10, 32'd3, 32'h0, 1'b0);
        wait_idle();
        chk("sub_rd", last_rd, 32'd7);
        chk("sub_we", {31'd0, last_we}, 32'd1);
        chk("sub_npc", last_npc, 32'h44);
        chk("sub_off", 32'(last_off), 32'd2);

        // BEQ taken
        issue(3'd3, 3'd0, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
        wait_idle();
        chk("beq_tgt_op", {28'd0, tgt_op}, 32'd0);
        chk("beq_tgt_a", tgt_a, 32'h100);
        chk("beq_tgt_b", tgt_b, 32'h20);
        chk("beq_npc", last_npc, 32'h120);
        chk("beq_we", {31'd0, last_we}, 32'd0);
        chk("beq_off", 32'(last_off), 32'd3);

        // BNE not taken
        issue(3'd3, 3'd1, 1'b0, 32'h100, 32'd9, 32'd9, 32'h40, 1'b0);
        wait_idle();
        chk("bne_npc", last_npc, 32'h104);
        chk("bne_off", 32'(last_off), 32'd2);

        // JALR
        issue(3'd5, 3'd0, 1'b0, 32'h80, 32'h203, 32'd0, 32'd4, 1'b0);
        wait_idle();
        chk("jalr_npc", last_npc, 32'h206);
        chk("jalr_rd", last_rd, 32'h84);
        chk("jalr_we", {31'd0, last_we}, 32'd1);

        // start held high through PCINC/EXEC/DONE, plus pc wrap
        d0 = done_count;
        wait_idle();
        issue(3'd1, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'd1, 32'd0, 32'd2, 1'b0);
        start_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start_i = 1'b0;
        chk("busy_one_done", 32'(done_count - d0), 32'd1);
        chk("wrap_npc", last_npc, 32'd0);
        chk("wrap_rd", last_rd, 32'd3);

        // reset while in EXEC
        issue(3'd0, 3'd0, 1'b0, 32'h200, 32'd1, 32'd2, 32'd0, 1'b0);
        @(posedge clk); #1;
        d0 = done_count;
        apply_reset();
        chk("rstx_done", {31'd0, done_o}, 32'd0);
        chk("rstx_busy", {31'd0, busy_o}, 32'd0);
        chk("rstx_op", {28'd0, alu_bus.alu_op_o}, 32'd15);
        repeat (3) begin @(posedge clk); #1; end
        chk("rstx_no_done", 32'(done_count - d0), 32'd0);
        issue(3'd0, 3'd4, 1'b0, 32'h300, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0);
        wait_idle();
        chk("after_rst_rd", last_rd, 32'hFF00);
        chk("after_rst_npc", last_npc, 32'h304);

        // randomized stream
        for (int i = 0; i < 300; i++) begin
            r1 = $urandom;
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom, r1,
                  ($urandom_range(0, 2) == 0) ? r1 : $urandom, $urandom,
                  1'($urandom_range(0, 1)));
        end
        wait_idle();
        repeat (2) begin @(posedge clk); #1; end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle execution sequencer that drives the shared combinational ALU on behalf of the multi-cycle RISC-V core. It accepts one decoded instruction per handshake, time-multiplexes the single ALU across PC-increment, execute and branch-target steps, and returns the write-back value and next PC. It is the initiator side of the ALU interface: it drives the op code and operands, and consumes the result and the branch condition.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start_i` in 1: instruction valid; sampled only in IDLE.
- `inst_class_i` in 3: 0 R-ALU, 1 I-ALU, 2 LD/ST address, 3 BRANCH, 4 JAL, 5 JALR, 6–7 illegal.
- `funct3_i` in 3: instruction funct3.
- `funct7b5_i` in 1: instruction bit 30.
- `pc_i` in 32: instruction PC.
- `rs1_i` in 32: first source operand.
- `rs2_i` in 32: second source operand.
- `imm_i` in 32: sign-extended immediate.
- `alu_op_o` out 4: ALU op code. ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, BEQ=7, BNE=8, BLT=9, BGE=10, NOP=15.
- `alu_a_o` out 32: ALU operand A.
- `alu_b_o` out 32: ALU operand B.
- `alu_p_i` in 32: ALU result.
- `bcond_i` in 1: ALU branch condition.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `rd_data_o` out 32: write-back value, or memory address for class 2.
- `rd_we_o` out 1: register write enable; valid with `done_o`.
- `next_pc_o` out 32: next PC; valid with `done_o`.

## Operation
- States: IDLE, PCINC, EXEC, TGT, DONE.
- **IDLE**
  - If `start_i`=1, latch all instruction inputs and go to PCINC.
  - While not in IDLE, `start_i` is ignored; there is no queueing.
- **PCINC**
  - Drive op ADD, a=pc, b=4.
  - Latch `alu_p_i` as pc4. Go to EXEC.
- **EXEC** (drives the ALU and latches results according to class):
  - R/I op from funct3:
    - 000: ADD, or SUB when R and funct7b5=1.
    - 001: SLL. 100: XOR. 101: SRL. 110: OR. 111: AND.
    - 010/011: unsupported. Drive NOP, result 0, rd_we=0.
  - R: a=rs1, b=rs2. I: a=rs1, b=imm. Result→rd, rd_we=1, next_pc=pc4.
  - LD/ST: ADD rs1+imm→rd_data, rd_we=0, next_pc=pc4.
  - BRANCH: a=rs1, b=rs2, op from funct3:
    - 000 BEQ, 001 BNE, 100 BLT, 101 BGE.
    - Other funct3: NOP, treated as not taken.
    - bcond=1 → go to TGT. Otherwise next_pc=pc4, rd_we=0.
  - JAL: ADD pc+imm → next_pc; rd=pc4, rd_we=1.
  - JALR: ADD rs1+imm, then bit0 cleared → next_pc; rd=pc4, rd_we=1.
  - Illegal class: NOP, rd_we=0, rd=0, next_pc=pc4.
  - All classes except a taken branch go to DONE.
- **TGT**
  - ADD pc+imm → next_pc, rd_we=0. Go to DONE.
- **DONE**
  - `done_o`=1 and results held. Return to IDLE.
  - A `start_i` seen in this cycle is ignored.
- ALU outputs in IDLE and DONE: op=15, a=0, b=0.
- Arithmetic: all 32-bit with wrap-around, carry discarded.
  - pc+4 from 0xFFFFFFFC → 0.
  - The branch comparison is whatever the ALU computes; no local comparison is made.
- Result registers hold their value from DONE until the next EXEC overwrites them.

## Timing
- Accept edge E0 (IDLE, `start_i`=1). States then run as follows:
  - PCINC: E0→E1.
  - EXEC: E1→E2.
  - Non-target path: DONE E2→E3, IDLE from E3. Earliest next accept is at edge E4.
  - Taken branch: TGT E2→E3, DONE E3→E4.
- `done_o` and `busy_o` are registered. `alu_*_o` are decoded from state and latched operands only; they never depend combinationally on `start_i`.
- `alu_p_i` and `bcond_i` are sampled at the end of the state that drives them. The ALU is combinational, so there is zero wait.
- Reset values:
  - State IDLE; latches cleared.
  - busy=0, done=0, rd_we=0, rd_data=0, next_pc=0.
  - alu_op=15, a=0, b=0.
- Reset asserted in any state:
  - IDLE after the edge; no `done_o` for the aborted instruction.
  - Reset dominates `start_i` on the same edge.

## Test plan
- **R SUB:** class 0, funct3 000, f7b5=1, rs1=10, rs2=3, pc=0x40.
  - `done_o` in cycle E2→E3 with rd=7, rd_we=1, next_pc=0x44.
  - busy high from E0 through E3.
- **BEQ taken:** class 3, funct3 000, rs1=rs2=5, pc=0x100, imm=0x20.
  - TGT state drives op 0, a=0x100, b=0x20.
  - `done_o` in E3→E4, next_pc=0x120, rd_we=0.
- **BNE not taken:** rs1=rs2=9, pc=0x100.
  - `done_o` in E2→E3, next_pc=0x104; TGT never entered.
- **JALR:** rs1=0x203, imm=4, pc=0x80.
  - next_pc=0x206, rd=0x84, rd_we=1.
- **Start during busy and wrap:**
  - Second `start_i` in PCINC/EXEC/DONE is ignored: exactly one `done_o`.
  - pc=0xFFFFFFFC gives next_pc=0.
- **Reset mid-EXEC:**
  - Assert in EXEC → IDLE, done=0, alu_op=15 next cycle.
  - A new start after reset completes normally.
